// File: rtl/grey_stream_ctrl.sv
// Frame/line sequencer between CCD capture and the greyscale converter: qualifies
// pixels against FVAL/LVAL, generates X/Y coordinates, latches mode, counts frames.
module grey_stream_ctrl #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 960
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  input  logic [1:0]  iMODE,
  input  logic        iFVAL,
  input  logic        iLVAL,
  input  logic        iDVAL,
  input  logic [11:0] iDATA,
  output logic [11:0] oDATA,
  output logic        oDVAL,
  output logic [10:0] oX_Cont,
  output logic [10:0] oY_Cont,
  output logic [1:0]  oMODE,
  output logic        oFRAME_DONE,
  output logic [15:0] oFRAME_CNT,
  output logic        oLINE_ERR,
  output logic        oBUSY,
  output logic [1:0]  oSTATE
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_SOF = 2'd1,
    S_ACTIVE   = 2'd2,
    S_EOF      = 2'd3
  } state_t;

  localparam logic [10:0] H_MAX = 11'(H_ACTIVE);
  localparam logic [10:0] V_MAX = 11'(V_ACTIVE);

  state_t      state_q, state_d;
  logic        fval_q, lval_q;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic [11:0] data_q;
  logic        dval_q, dval_d;
  logic [10:0] ox_q, ox_d, oy_q, oy_d;
  logic [1:0]  mode_q, mode_d;
  logic        done_q, done_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;

  logic fval_rise, fval_fall, lval_fall;
  assign fval_rise = iFVAL & ~fval_q;
  assign fval_fall = ~iFVAL & fval_q;
  assign lval_fall = ~iLVAL & lval_q;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dval_d  = 1'b0;
    ox_d    = ox_q;
    oy_d    = oy_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (iSTART) state_d = S_WAIT_SOF;
      end
      S_WAIT_SOF: begin
        // Only a fresh rising edge starts a frame, so a frame already in flight is skipped.
        if (fval_rise) begin
          state_d = S_ACTIVE;
          mode_d  = iMODE;
          x_d     = 11'd0;
          y_d     = 11'd0;
        end
      end
      S_ACTIVE: begin
        if (iDVAL && iLVAL && (x_q < H_MAX)) begin
          x_d = x_q + 11'd1;
          if (y_q < V_MAX) begin
            dval_d = 1'b1;
            ox_d   = x_q;
            oy_d   = y_q;
          end
        end
        if (lval_fall) begin
          if (x_q != H_MAX) err_d = 1'b1;
          x_d = 11'd0;
          if (y_q < V_MAX) y_d = y_q + 11'd1;
        end
        if (fval_fall) begin
          state_d = S_EOF;
          done_d  = 1'b1;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      S_EOF: begin
        state_d = iSTART ? S_WAIT_SOF : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q <= S_IDLE;
      fval_q  <= 1'b0;
      lval_q  <= 1'b0;
      x_q     <= 11'd0;
      y_q     <= 11'd0;
      data_q  <= 12'd0;
      dval_q  <= 1'b0;
      ox_q    <= 11'd0;
      oy_q    <= 11'd0;
      mode_q  <= 2'd0;
      done_q  <= 1'b0;
      cnt_q   <= 16'd0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fval_q  <= iFVAL;
      lval_q  <= iLVAL;
      x_q     <= x_d;
      y_q     <= y_d;
      data_q  <= iDATA;
      dval_q  <= dval_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign oDATA       = data_q;
  assign oDVAL       = dval_q;
  assign oX_Cont     = ox_q;
  assign oY_Cont     = oy_q;
  assign oMODE       = mode_q;
  assign oFRAME_DONE = done_q;
  assign oFRAME_CNT  = cnt_q;
  assign oLINE_ERR   = err_q;
  assign oBUSY       = busy_q;
  assign oSTATE      = state_q;

endmodule
